// File: rtl/tpm_port_ctrl.sv
// Front-end controller mapping two read ports (A, B) and one write port (W) onto a 1rw1r SRAM.
// Optional macro TPM_WR_BYPASS_EN: forward same-cycle W data to a colliding A read instead of stalling A.

module tpm_resp_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_ready_i,
    output logic             rvalid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Head entry is read straight from storage, so it cannot change until popped.
    assign rvalid_o = (count_q != '0);
    assign pop      = rvalid_o & pop_ready_i;
    assign rdata_o  = mem_q[rd_ptr_q];
    assign count_o  = count_q;

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end
endmodule

module tpm_port_ctrl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 16,
    parameter int RESP_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DEPTH_LOG2-1:0] a_addr,
    output logic                  a_rvalid,
    input  logic                  a_rready,
    output logic [WIDTH-1:0]      a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [DEPTH_LOG2-1:0] b_addr,
    output logic                  b_rvalid,
    input  logic                  b_rready,
    output logic [WIDTH-1:0]      b_rdata,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DEPTH_LOG2-1:0] w_addr,
    input  logic [WIDTH-1:0]      w_data,
    output logic                  sram_r_valid,
    output logic [DEPTH_LOG2-1:0] sram_r_addr,
    input  logic [WIDTH-1:0]      sram_r_data_out,
    output logic                  sram_rw_valid,
    output logic                  sram_rw_w_en,
    output logic [DEPTH_LOG2-1:0] sram_rw_addr,
    output logic [WIDTH-1:0]      sram_rw_data_in,
    input  logic [WIDTH-1:0]      sram_rw_data_out
);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    if (RESP_DEPTH < 3) begin : g_bad_depth
        $error("tpm_port_ctrl: RESP_DEPTH must be at least 3");
    end

    logic [CW-1:0]    a_cnt, b_cnt;
    logic             a_inflight_q, a_inflight_d;
    logic             b_inflight_q, b_inflight_d;
    logic             last_w_q, last_w_d;
    logic             a_room, b_elig, b_req, a_collide;
    logic             a_fire, b_fire;
    logic             w_grant, b_grant;
    logic [WIDTH-1:0] a_push_data;

    // Handshakes: a request or response transfers on a cycle where valid and ready are both high;
    // ready never looks at a_rready/b_rready, and every SRAM strobe is a pure function of this cycle's transfer.
    assign a_room = (32'(a_cnt) + 32'(a_inflight_q)) < 32'(RESP_DEPTH);
    assign b_elig = (32'(b_cnt) + 32'(b_inflight_q)) < 32'(RESP_DEPTH);
    assign b_req  = b_valid & b_elig;

    always_comb begin
        w_grant = 1'b0;
        b_grant = 1'b0;
        if (!rst) begin
            if (b_req && w_valid) begin
                w_grant = ~last_w_q;
                b_grant = last_w_q;
            end else begin
                w_grant = w_valid;
                b_grant = b_req;
            end
        end
    end

`ifdef TPM_WR_BYPASS_EN
    logic             byp_hit_q, byp_hit_d;
    logic [WIDTH-1:0] byp_data_q, byp_data_d;

    assign a_collide   = 1'b0;
    assign byp_hit_d   = a_fire & w_grant & (a_addr == w_addr);
    assign byp_data_d  = byp_hit_d ? w_data : byp_data_q;
    // The SRAM returns pre-write data on a same-address collision, so substitute the write data.
    assign a_push_data = byp_hit_q ? byp_data_q : sram_r_data_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= byp_data_d;
        end
    end
`else
    assign a_collide   = w_grant & (a_addr == w_addr);
    assign a_push_data = sram_r_data_out;
`endif

    assign a_ready = ~rst & a_room & ~a_collide;
    assign b_ready = b_grant;
    assign w_ready = w_grant;
    assign a_fire  = a_valid & a_ready;
    assign b_fire  = b_grant;

    assign sram_r_valid    = a_fire;
    assign sram_r_addr     = a_fire ? a_addr : '0;
    assign sram_rw_valid   = b_fire | w_grant;
    assign sram_rw_w_en    = w_grant;
    assign sram_rw_addr    = w_grant ? w_addr : (b_fire ? b_addr : '0);
    assign sram_rw_data_in = w_grant ? w_data : '0;

    assign a_inflight_d = a_fire;
    assign b_inflight_d = b_fire;
    assign last_w_d     = w_grant ? 1'b1 : (b_grant ? 1'b0 : last_w_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_inflight_q <= 1'b0;
            b_inflight_q <= 1'b0;
            last_w_q     <= 1'b0;
        end else begin
            a_inflight_q <= a_inflight_d;
            b_inflight_q <= b_inflight_d;
            last_w_q     <= last_w_d;
        end
    end

    tpm_resp_fifo #(.WIDTH(WIDTH), .DEPTH(RESP_DEPTH), .CW(CW)) u_a_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (a_inflight_q),
        .push_data_i (a_push_data),
        .pop_ready_i (a_rready),
        .rvalid_o    (a_rvalid),
        .rdata_o     (a_rdata),
        .count_o     (a_cnt)
    );

    tpm_resp_fifo #(.WIDTH(WIDTH), .DEPTH(RESP_DEPTH), .CW(CW)) u_b_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (b_inflight_q),
        .push_data_i (sram_rw_data_out),
        .pop_ready_i (b_rready),
        .rvalid_o    (b_rvalid),
        .rdata_o     (b_rdata),
        .count_o     (b_cnt)
    );
endmodule

// File: tb/tb_tpm_port_ctrl.sv
// Bench for tpm_port_ctrl: behavioural SRAM, reference memory model, and queue-based response scoreboard.
module tb_tpm_port_ctrl;
  localparam int AW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 0, a_ready, a_rvalid, a_rready = 0;
  logic b_valid = 0, b_ready, b_rvalid, b_rready = 0;
  logic w_valid = 0, w_ready;
  logic [AW-1:0] a_addr = '0, b_addr = '0, w_addr = '0;
  logic [DW-1:0] a_rdata, b_rdata, w_data = '0;
  logic sram_r_valid, sram_rw_valid, sram_rw_w_en;
  logic [AW-1:0] sram_r_addr, sram_rw_addr;
  logic [DW-1:0] sram_r_data_out, sram_rw_data_in, sram_rw_data_out;

  tpm_port_ctrl dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr),
    .a_rvalid(a_rvalid), .a_rready(a_rready), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr),
    .b_rvalid(b_rvalid), .b_rready(b_rready), .b_rdata(b_rdata),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .sram_r_valid(sram_r_valid), .sram_r_addr(sram_r_addr), .sram_r_data_out(sram_r_data_out),
    .sram_rw_valid(sram_rw_valid), .sram_rw_w_en(sram_rw_w_en), .sram_rw_addr(sram_rw_addr),
    .sram_rw_data_in(sram_rw_data_in), .sram_rw_data_out(sram_rw_data_out)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // behavioural 1rw1r SRAM: synchronous read, read-before-write on same edge
  logic [DW-1:0] sram_mem [1024];
  logic [DW-1:0] model_mem [1024];
  logic [DW-1:0] r_out = '0, rw_out = '0;
  assign sram_r_data_out  = r_out;
  assign sram_rw_data_out = rw_out;

  function automatic logic [DW-1:0] init_val(input int i);
    return 16'((i * 40503) ^ 16'h5A5A);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] <= init_val(i);
      model_mem[i] = init_val(i);
    end
  end

  always @(posedge clk) begin
    if (sram_r_valid) r_out <= sram_mem[sram_r_addr];
    if (sram_rw_valid) begin
      if (sram_rw_w_en) sram_mem[sram_rw_addr] <= sram_rw_data_in;
      else rw_out <= sram_mem[sram_rw_addr];
    end
  end

  // check bookkeeping
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // scoreboard
  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];
  int a_pop_cyc_q[$];
  int b_pop_cnt = 0;
  logic a_hold = 0, b_hold = 0;
  logic [DW-1:0] a_hold_data = '0, b_hold_data = '0;
  logic [DW-1:0] exp_v;
  logic a_f, b_f, w_f;

  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", {31'b0, |{a_ready, b_ready, w_ready, a_rvalid, b_rvalid, a_rdata, b_rdata,
            sram_r_valid, sram_r_addr, sram_rw_valid, sram_rw_w_en, sram_rw_addr, sram_rw_data_in}}, 32'd0);
      exp_a_q.delete();
      exp_b_q.delete();
      a_hold = 0;
      b_hold = 0;
    end else begin
      a_f = a_valid & a_ready;
      b_f = b_valid & b_ready;
      w_f = w_valid & w_ready;
      check("bw_exclusive", {31'b0, b_ready & w_ready}, 32'd0);
      if (a_f) begin
        exp_v = (w_f && w_addr == a_addr) ? w_data : model_mem[a_addr];
        exp_a_q.push_back(exp_v);
        check("sram_r_addr", {21'b0, sram_r_valid, sram_r_addr}, {21'b0, 1'b1, a_addr});
      end else begin
        check("sram_r_idle", {31'b0, sram_r_valid}, 32'd0);
      end
      if (b_f) begin
        exp_b_q.push_back(model_mem[b_addr]);
        check("sram_rw_bread", {20'b0, sram_rw_valid, sram_rw_w_en, sram_rw_addr}, {20'b0, 2'b10, b_addr});
      end
      if (w_f) begin
        check("sram_rw_write", {4'b0, sram_rw_valid, sram_rw_w_en, sram_rw_addr, sram_rw_data_in},
              {4'b0, 2'b11, w_addr, w_data});
        model_mem[w_addr] = w_data;
      end
      if (!b_f && !w_f) check("sram_rw_idle", {31'b0, sram_rw_valid}, 32'd0);

      if (a_hold) check("a_rdata_hold", {15'b0, a_rvalid, a_rdata}, {15'b0, 1'b1, a_hold_data});
      if (b_hold) check("b_rdata_hold", {15'b0, b_rvalid, b_rdata}, {15'b0, 1'b1, b_hold_data});
      if (a_rvalid && a_rready) begin
        a_pop_cyc_q.push_back(cyc);
        if (exp_a_q.size() == 0) check("a_resp_unexpected", {16'b0, a_rdata}, 32'hFFFF_FFFF);
        else check("a_rdata", {16'b0, a_rdata}, {16'b0, exp_a_q.pop_front()});
      end
      if (b_rvalid && b_rready) begin
        b_pop_cnt++;
        if (exp_b_q.size() == 0) check("b_resp_unexpected", {16'b0, b_rdata}, 32'hFFFF_FFFF);
        else check("b_rdata", {16'b0, b_rdata}, {16'b0, exp_b_q.pop_front()});
      end
      a_hold = a_rvalid & ~a_rready;
      a_hold_data = a_rdata;
      b_hold = b_rvalid & ~b_rready;
      b_hold_data = b_rdata;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    a_valid = 0; b_valid = 0; w_valid = 0;
    rst = 1;
    wait_cycles(3);
    rst = 0;
  endtask

  int acc;
  bit a_acc, b_acc, w_acc;

  initial begin
    step();
    do_reset();

    // write 0xBEEF @1, then read it on A with the documented latency
    a_rready = 1; b_rready = 1;
    w_valid = 1; w_addr = 10'h001; w_data = 16'hBEEF;
    @(negedge clk); check("t1_w_ready", {31'b0, w_ready}, 32'd1);
    step();
    w_valid = 0;
    a_valid = 1; a_addr = 10'h001;
    @(negedge clk); check("t1_a_ready", {31'b0, a_ready}, 32'd1);
    step();
    a_valid = 0;
    @(negedge clk); check("t1_rvalid_n1", {31'b0, a_rvalid}, 32'd0);
    step();
    @(negedge clk); check("t1_rvalid_n2", {15'b0, a_rvalid, a_rdata}, {15'b0, 1'b1, 16'hBEEF});
    step();

    // back-to-back burst @0..7
    wait_cycles(3);
    a_pop_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      a_valid = 1; a_addr = 10'(i);
      @(negedge clk); check("t2_a_ready", {31'b0, a_ready}, 32'd1);
      step();
    end
    a_valid = 0;
    wait_cycles(6);
    check("t2_resp_count", 32'(a_pop_cyc_q.size()), 32'd8);
    if (a_pop_cyc_q.size() == 8)
      check("t2_consecutive", 32'(a_pop_cyc_q[7] - a_pop_cyc_q[0]), 32'd7);

    // backpressure: FIFO fills after exactly RESP_DEPTH accepts
    a_rready = 0; acc = 0;
    a_valid = 1; a_addr = 10'h020;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); a_acc = a_ready;
      step();
      if (a_acc) begin acc++; a_addr = 10'(10'h020 + acc); end
    end
    check("t3_accepts", 32'(acc), 32'd3);
    @(negedge clk); check("t3_a_ready_low", {31'b0, a_ready}, 32'd0);
    step();
    a_valid = 0;
    a_pop_cyc_q.delete();
    a_rready = 1;
    wait_cycles(5);
    check("t3_drain_count", 32'(a_pop_cyc_q.size()), 32'd3);
    a_valid = 1; a_addr = 10'h030;
    @(negedge clk); check("t3_resume", {31'b0, a_ready}, 32'd1);
    step();
    a_valid = 0;
    wait_cycles(4);

    // B/W contention alternates W, B, W, B after reset
    do_reset();
    a_rready = 1; b_rready = 1;
    b_valid = 1; b_addr = 10'($urandom_range(64, 127));
    w_valid = 1; w_addr = 10'($urandom_range(128, 191)); w_data = 16'($urandom);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      w_acc = w_ready; b_acc = b_ready;
      check("t4_w_grant", {31'b0, w_ready}, {31'b0, (k % 2) == 0});
      check("t4_b_grant", {31'b0, b_ready}, {31'b0, (k % 2) == 1});
      check("t4_w_en", {31'b0, sram_rw_w_en}, {31'b0, (k % 2) == 0});
      step();
      if (w_acc) begin w_addr = 10'($urandom_range(128, 191)); w_data = 16'($urandom); end
      if (b_acc) b_addr = 10'($urandom_range(64, 127));
    end
    b_valid = 0; w_valid = 0;
    wait_cycles(4);

    // same-cycle A read and W write of 0x1234 @0x3FF
    a_pop_cyc_q.delete();
    a_valid = 1; a_addr = 10'h3FF;
    w_valid = 1; w_addr = 10'h3FF; w_data = 16'h1234;
    @(negedge clk);
    check("t5_w_ready", {31'b0, w_ready}, 32'd1);
`ifdef TPM_WR_BYPASS_EN
    check("t5_a_ready_bypass", {31'b0, a_ready}, 32'd1);
    step();
    a_valid = 0; w_valid = 0;
`else
    check("t5_a_ready_stall", {31'b0, a_ready}, 32'd0);
    step();
    w_valid = 0;
    @(negedge clk); check("t5_a_ready_retry", {31'b0, a_ready}, 32'd1);
    step();
    a_valid = 0;
`endif
    wait_cycles(4);
    check("t5_resp_count", 32'(a_pop_cyc_q.size()), 32'd1);

    // reset with two A reads in flight
    a_rready = 0;
    a_valid = 1; a_addr = 10'h055;
    @(negedge clk); check("t6_acc1", {31'b0, a_ready}, 32'd1);
    step();
    a_addr = 10'h056;
    @(negedge clk); check("t6_acc2", {31'b0, a_ready}, 32'd1);
    step();
    a_valid = 0;
    rst = 1;
    #1;
    check("t6_rvalid_async", {30'b0, a_rvalid, a_ready}, 32'd0);
    wait_cycles(2);
    rst = 0;
    a_rready = 1;
    a_pop_cyc_q.delete();
    wait_cycles(6);
    check("t6_no_stale_resp", 32'(a_pop_cyc_q.size()), 32'd0);
    a_valid = 1; a_addr = 10'h056;
    step();
    a_valid = 0;
    wait_cycles(4);
    check("t6_new_resp", 32'(a_pop_cyc_q.size()), 32'd1);

    // randomized mixed traffic over a small address window
    b_pop_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      a_acc = a_valid & a_ready; b_acc = b_valid & b_ready; w_acc = w_valid & w_ready;
      step();
      if (!a_valid || a_acc) begin a_valid = ($urandom_range(0, 2) != 0); a_addr = 10'($urandom_range(0, 15)); end
      if (!b_valid || b_acc) begin b_valid = ($urandom_range(0, 2) != 0); b_addr = 10'($urandom_range(0, 15)); end
      if (!w_valid || w_acc) begin
        w_valid = ($urandom_range(0, 2) != 0);
        w_addr = 10'($urandom_range(0, 15));
        w_data = 16'($urandom);
      end
      a_rready = ($urandom_range(0, 3) != 0);
      b_rready = ($urandom_range(0, 3) != 0);
    end
    a_valid = 0; b_valid = 0; w_valid = 0;
    a_rready = 1; b_rready = 1;
    wait_cycles(10);
    check("rand_b_activity", {31'b0, b_pop_cnt > 20}, 32'd1);
    check("end_a_queue_empty", 32'(exp_a_q.size()), 32'd0);
    check("end_b_queue_empty", 32'(exp_b_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tpm_port_ctrl.md
# tpm_port_ctrl

Front-end controller for the triple-ported memory. It presents two read request ports (A, B) and one write request port (W), each with a valid/ready handshake, and maps them onto a 1024x16 1rw1r SRAM macro. Port A uses the SRAM r port. B and W share the SRAM rw port under round-robin arbitration. Each read port has a 3-entry response FIFO, so read data is returned with a valid/ready handshake at full throughput.

## Interface
- `DEPTH_LOG2`, default 10: SRAM address width.
- `WIDTH`, default 16: data width.
- `RESP_DEPTH`, default 3: per-read-port response FIFO depth. Values below 3 are illegal.

Ports:
- `clk` in 1: single clock for all logic and the SRAM.
- `rst` in 1: asynchronous, active-high reset.
- `a_valid` / `a_ready` in/out 1, `a_addr` in DEPTH_LOG2: read request, port A.
- `a_rvalid` out 1, `a_rready` in 1, `a_rdata` out WIDTH: read response, port A.
- `b_valid` / `b_ready` in/out 1, `b_addr` in DEPTH_LOG2: read request, port B.
- `b_rvalid` out 1, `b_rready` in 1, `b_rdata` out WIDTH: read response, port B.
- `w_valid` / `w_ready` in/out 1, `w_addr` in DEPTH_LOG2, `w_data` in WIDTH: write request.
- `sram_r_valid` out 1, `sram_r_addr` out DEPTH_LOG2, `sram_r_data_out` in WIDTH: SRAM read port.
- `sram_rw_valid` out 1, `sram_rw_w_en` out 1, `sram_rw_addr` out DEPTH_LOG2, `sram_rw_data_in` out WIDTH, `sram_rw_data_out` in WIDTH: SRAM rw port.

## Operation
- A request is accepted in any cycle where valid and ready are both high. All SRAM-side outputs are combinational from the accepted request and are 0 when nothing is accepted.
- Port A:
  - `a_ready` = (`a_cnt` + `a_inflight` < RESP_DEPTH) and no collision stall (see Configuration).
  - On accept: `sram_r_valid`=1, `sram_r_addr`=`a_addr`.
- Port B / W arbitration:
  - When only one of B and W is requesting and eligible, it wins.
  - When both are eligible, the winner is the opposite of the `last_w` flag.
  - `last_w` is updated on every grant. Reset value 0, so the write wins the first contention.
  - B is eligible only when `b_cnt` + `b_inflight` < RESP_DEPTH.
  - `b_ready` = B granted; `w_ready` = W granted.
  - A B grant drives `sram_rw_valid`=1, `sram_rw_w_en`=0. A W grant drives `sram_rw_valid`=1, `sram_rw_w_en`=1, `sram_rw_data_in`=`w_data`.
- In-flight tracking: `a_inflight` / `b_inflight` are set in the cycle after an accept. In that cycle `sram_*_data_out` is captured into the port's FIFO at the clock edge.
- Response FIFOs:
  - In-order, depth RESP_DEPTH.
  - `rvalid` = FIFO non-empty; `rdata` = head entry, a registered value.
  - Pop on `rvalid & rready`. Push and pop in the same cycle keep the count unchanged.
  - `rdata` must be held stable while `rvalid & ~rready`.
- Write-only traffic produces no response.
- ready outputs never depend on `a_rready` / `b_rready` (no combinational return path).

## Timing
- Read latency: accept in cycle N, SRAM data valid in cycle N+1, `rvalid` with data in cycle N+2 if the FIFO was empty.
- Throughput: one read per cycle per port while `rready` is held high. Steady state is count 1 + inflight 1, which is below 3.
- Write: committed at the edge closing the accept cycle. A read accepted in a later cycle returns the new data.
- Reset: asynchronous assert clears FIFOs, inflight flags and `last_w`.
  - During reset, all outputs are 0: `*_ready`, `*_rvalid`, `*_rdata`, and all `sram_*`.
  - In-flight reads are dropped, with no response after reset release.
- First accept is possible in the first cycle after `rst` deasserts.

## Configuration
- `TPM_WR_BYPASS_EN` defined:
  - A port-A read accepted in the same cycle as a W write to the same address is accepted normally.
  - Its FIFO entry takes the captured `w_data` instead of `sram_r_data_out`.
  - The extra state is one address-match flag plus one WIDTH-bit data register.
- `TPM_WR_BYPASS_EN` not defined:
  - A collision (`a_addr` == `w_addr` with W granted) forces `a_ready`=0 for that cycle, so A retries the next cycle and reads the committed data.

## Test plan
- Reset, then write 0xBEEF @0x001 via W; next cycle read A @0x001 -> `a_rvalid` 2 cycles later with `a_rdata`=0xBEEF.
- A reads @0..7 back-to-back with `a_rready`=1 -> `a_ready` stays 1 and eight responses arrive on consecutive cycles, in order.
- A read with `a_rready`=0 for 10 cycles -> exactly 3 accepts, then `a_ready`=0; `a_rdata` stable. Release `a_rready` -> 3 responses, then accepts resume.
- B and W valid continuously -> grants alternate W, B, W, B; `sram_rw_w_en` toggles 1, 0, 1, 0.
- Same-cycle A read and W write of 0x1234 @0x3FF:
  - With `TPM_WR_BYPASS_EN`: A is accepted and returns 0x1234.
  - Without it: `a_ready`=0 that cycle, A is accepted next cycle and returns 0x1234.
- Assert `rst` with 2 reads in flight on A -> `a_rvalid`=0 immediately; no responses after release; the first new read returns the correct data.
